// File: rtl/ysyx_24080006_pkg.sv
// Shared AXI read-channel types, FSM state encoding and CLINT decode defaults
// for the ysyx_24080006 read arbiter.
package ysyx_24080006_pkg;

  localparam logic [31:0] CLINT_BASE_DEFAULT = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK_DEFAULT = 32'hFFFF_0000;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;
  } axi_r_s2m_t;

  // AR fields captured at grant time
  typedef struct packed {
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
  } ar_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } rd_state_e;

  typedef enum logic {
    GNT_IFU,
    GNT_LSU
  } rd_grant_e;

  typedef enum logic {
    TGT_CORE,
    TGT_CLINT
  } rd_target_e;

  function automatic ar_fields_t to_ar_fields(input axi_r_m2s_t m);
    ar_fields_t f;
    f.araddr  = m.araddr;
    f.arid    = m.arid;
    f.arlen   = m.arlen;
    f.arsize  = m.arsize;
    f.arburst = m.arburst;
    return f;
  endfunction

endpackage

// File: rtl/ysyx_24080006_rd_arbiter_if.sv
// Bundles one AXI read channel pair (request + response) for connecting
// requesters and targets to the read arbiter.
interface ysyx_24080006_rd_arbiter_if;
  import ysyx_24080006_pkg::*;

  axi_r_m2s_t m2s;
  axi_r_s2m_t s2m;

  modport master (output m2s, input s2m);
  modport slave  (input m2s, output s2m);
endinterface

// File: rtl/ysyx_24080006_rd_arbiter.sv
// Two-requester (IFU, LSU) AXI read arbiter routing to CLINT or the external
// port; one outstanding transaction, LSU has priority.
module ysyx_24080006_rd_arbiter
  import ysyx_24080006_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
  parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t ifu_r_m2s,
  output axi_r_s2m_t ifu_r_s2m,
  input  axi_r_m2s_t lsu_r_m2s,
  output axi_r_s2m_t lsu_r_s2m,
  output axi_r_m2s_t clint_r_m2s,
  input  axi_r_s2m_t clint_r_s2m,
  output axi_r_m2s_t core_r_m2s,
  input  axi_r_s2m_t core_r_s2m
);

  rd_state_e  state_q;
  rd_grant_e  gnt_q;
  rd_target_e tgt_q;
  ar_fields_t ar_q;

  axi_r_m2s_t req_sel;   // requester that would win this IDLE cycle
  axi_r_m2s_t gnt_m2s;
  axi_r_s2m_t tgt_s2m;
  axi_r_m2s_t tgt_drv;
  axi_r_s2m_t req_drv;

  always_comb begin
    req_sel = lsu_r_m2s.arvalid ? lsu_r_m2s : ifu_r_m2s;
    gnt_m2s = (gnt_q == GNT_LSU)   ? lsu_r_m2s   : ifu_r_m2s;
    tgt_s2m = (tgt_q == TGT_CLINT) ? clint_r_s2m : core_r_s2m;
  end

  // Outputs are forced to zero while reset is held, regardless of the
  // state register's value before the reset edge.
  always_comb begin
    ifu_r_s2m   = '0;
    lsu_r_s2m   = '0;
    clint_r_m2s = '0;
    core_r_m2s  = '0;
    tgt_drv     = '0;
    req_drv     = '0;
    if (reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (lsu_r_m2s.arvalid)      lsu_r_s2m.arready = 1'b1;
          else if (ifu_r_m2s.arvalid) ifu_r_s2m.arready = 1'b1;
        end
        ST_ADDR: begin
          tgt_drv.arvalid = 1'b1;
          tgt_drv.araddr  = ar_q.araddr;
          tgt_drv.arid    = ar_q.arid;
          tgt_drv.arlen   = ar_q.arlen;
          tgt_drv.arsize  = ar_q.arsize;
          tgt_drv.arburst = ar_q.arburst;
        end
        ST_DATA: begin
          tgt_drv.rready = gnt_m2s.rready;
          req_drv.rvalid = tgt_s2m.rvalid;
          req_drv.rdata  = tgt_s2m.rdata;
          req_drv.rlast  = tgt_s2m.rlast;
          req_drv.rresp  = tgt_s2m.rresp;
        end
        default: ;
      endcase
      if (tgt_q == TGT_CLINT) clint_r_m2s = tgt_drv;
      else                    core_r_m2s  = tgt_drv;
      if (state_q == ST_DATA) begin
        if (gnt_q == GNT_LSU) lsu_r_s2m = req_drv;
        else                  ifu_r_s2m = req_drv;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_IFU;
      tgt_q   <= TGT_CORE;
      ar_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (lsu_r_m2s.arvalid || ifu_r_m2s.arvalid) begin
            gnt_q   <= lsu_r_m2s.arvalid ? GNT_LSU : GNT_IFU;
            ar_q    <= to_ar_fields(req_sel);
            tgt_q   <= ((req_sel.araddr & CLINT_MASK) == CLINT_BASE) ? TGT_CLINT : TGT_CORE;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (tgt_s2m.arready) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (tgt_s2m.rvalid && gnt_m2s.rready && tgt_s2m.rlast) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_rd_arbiter.sv
// Directed bench for the read arbiter: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_ysyx_24080006_rd_arbiter;
  import ysyx_24080006_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ysyx_24080006_rd_arbiter_if ifu_if ();
  ysyx_24080006_rd_arbiter_if lsu_if ();
  ysyx_24080006_rd_arbiter_if clint_if ();
  ysyx_24080006_rd_arbiter_if core_if ();

  ysyx_24080006_rd_arbiter #(
    .CLINT_BASE (32'h0200_0000),
    .CLINT_MASK (32'hFFFF_0000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ifu_r_m2s   (ifu_if.m2s),
    .ifu_r_s2m   (ifu_if.s2m),
    .lsu_r_m2s   (lsu_if.m2s),
    .lsu_r_s2m   (lsu_if.s2m),
    .clint_r_m2s (clint_if.m2s),
    .clint_r_s2m (clint_if.s2m),
    .core_r_m2s  (core_if.m2s),
    .core_r_s2m  (core_if.s2m)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ifu_if.m2s   = '0;
    lsu_if.m2s   = '0;
    clint_if.s2m = '0;
    core_if.s2m  = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    nxt();
    ifu_if.m2s.arvalid = 1'b1;
    ifu_if.m2s.araddr  = 32'h3000_0000;
    settle();
    chk("rst_ifu_arready", 32'(ifu_if.s2m.arready), 32'd0);
    chk("rst_core_arvalid", 32'(core_if.m2s.arvalid), 32'd0);
    nxt();
    reset = 1'b1;

    // IFU alone, single beat to external port
    ifu_if.m2s.arid = 4'd2;
    settle();
    chk("t1_ifu_arready", 32'(ifu_if.s2m.arready), 32'd1);
    chk("t1_lsu_arready", 32'(lsu_if.s2m.arready), 32'd0);
    chk("t1_core_arvalid_grant", 32'(core_if.m2s.arvalid), 32'd0);
    nxt();
    ifu_if.m2s = '0;
    settle();
    chk("t1_core_arvalid", 32'(core_if.m2s.arvalid), 32'd1);
    chk("t1_core_araddr", core_if.m2s.araddr, 32'h3000_0000);
    chk("t1_core_arid", 32'(core_if.m2s.arid), 32'd2);
    chk("t1_clint_arvalid", 32'(clint_if.m2s.arvalid), 32'd0);
    chk("t1_ifu_arready_addr", 32'(ifu_if.s2m.arready), 32'd0);
    core_if.s2m.arready = 1'b1;
    nxt();
    core_if.s2m = '0;
    core_if.s2m.rvalid = 1'b1;
    core_if.s2m.rdata  = 32'hDEAD_BEEF;
    core_if.s2m.rlast  = 1'b1;
    ifu_if.m2s.rready  = 1'b1;
    settle();
    chk("t1_core_arvalid_data", 32'(core_if.m2s.arvalid), 32'd0);
    chk("t1_ifu_rvalid", 32'(ifu_if.s2m.rvalid), 32'd1);
    chk("t1_ifu_rdata", ifu_if.s2m.rdata, 32'hDEAD_BEEF);
    chk("t1_ifu_rlast", 32'(ifu_if.s2m.rlast), 32'd1);
    chk("t1_lsu_rvalid", 32'(lsu_if.s2m.rvalid), 32'd0);
    chk("t1_lsu_rdata", lsu_if.s2m.rdata, 32'd0);
    chk("t1_core_rready", 32'(core_if.m2s.rready), 32'd1);
    nxt();
    clear_inputs();
    ifu_if.m2s.rready = 1'b1;
    settle();
    chk("t1_idle_core_rready", 32'(core_if.m2s.rready), 32'd0);
    chk("t1_idle_core_arvalid", 32'(core_if.m2s.arvalid), 32'd0);

    // IFU and LSU together: LSU wins and goes to CLINT
    clear_inputs();
    ifu_if.m2s.arvalid = 1'b1;
    ifu_if.m2s.araddr  = 32'h3000_0200;
    lsu_if.m2s.arvalid = 1'b1;
    lsu_if.m2s.araddr  = 32'h0200_BFF8;
    lsu_if.m2s.arsize  = 3'd2;
    settle();
    chk("t2_lsu_arready", 32'(lsu_if.s2m.arready), 32'd1);
    chk("t2_ifu_arready", 32'(ifu_if.s2m.arready), 32'd0);
    nxt();
    lsu_if.m2s = '0;
    settle();
    chk("t2_clint_arvalid", 32'(clint_if.m2s.arvalid), 32'd1);
    chk("t2_clint_araddr", clint_if.m2s.araddr, 32'h0200_BFF8);
    chk("t2_clint_arsize", 32'(clint_if.m2s.arsize), 32'd2);
    chk("t2_core_arvalid", 32'(core_if.m2s.arvalid), 32'd0);
    chk("t2_core_araddr", core_if.m2s.araddr, 32'd0);
    chk("t2_ifu_arready_addr", 32'(ifu_if.s2m.arready), 32'd0);
    clint_if.s2m.arready = 1'b1;
    nxt();
    clint_if.s2m = '0;
    clint_if.s2m.rvalid = 1'b1;
    clint_if.s2m.rdata  = 32'h1234_5678;
    clint_if.s2m.rlast  = 1'b1;
    clint_if.s2m.rresp  = 2'b10;
    lsu_if.m2s.rready   = 1'b1;
    settle();
    chk("t2_lsu_rdata", lsu_if.s2m.rdata, 32'h1234_5678);
    chk("t2_lsu_rresp", 32'(lsu_if.s2m.rresp), 32'd2);
    chk("t2_ifu_rvalid", 32'(ifu_if.s2m.rvalid), 32'd0);
    chk("t2_ifu_arready_data", 32'(ifu_if.s2m.arready), 32'd0);
    chk("t2_clint_rready", 32'(clint_if.m2s.rready), 32'd1);
    chk("t2_core_rready", 32'(core_if.m2s.rready), 32'd0);
    nxt();
    clint_if.s2m = '0;
    lsu_if.m2s   = '0;
    settle();
    chk("t2_ifu_arready_after", 32'(ifu_if.s2m.arready), 32'd1);
    nxt();
    ifu_if.m2s = '0;
    settle();
    chk("t2_core_arvalid_ifu", 32'(core_if.m2s.arvalid), 32'd1);
    chk("t2_core_araddr_ifu", core_if.m2s.araddr, 32'h3000_0200);
    core_if.s2m.arready = 1'b1;
    nxt();
    core_if.s2m = '0;
    core_if.s2m.rvalid = 1'b1;
    core_if.s2m.rlast  = 1'b1;
    core_if.s2m.rdata  = 32'h0000_00A5;
    ifu_if.m2s.rready  = 1'b1;
    settle();
    chk("t2_ifu_rdata", ifu_if.s2m.rdata, 32'h0000_00A5);
    nxt();
    clear_inputs();

    // IFU burst of four beats while LSU waits
    ifu_if.m2s.arvalid = 1'b1;
    ifu_if.m2s.araddr  = 32'h3000_0100;
    ifu_if.m2s.arlen   = 8'd3;
    ifu_if.m2s.arburst = 2'b01;
    settle();
    chk("t3_ifu_arready", 32'(ifu_if.s2m.arready), 32'd1);
    nxt();
    ifu_if.m2s = '0;
    settle();
    chk("t3_core_arlen", 32'(core_if.m2s.arlen), 32'd3);
    chk("t3_core_arburst", 32'(core_if.m2s.arburst), 32'd1);
    core_if.s2m.arready = 1'b1;
    nxt();
    core_if.s2m = '0;
    ifu_if.m2s.rready  = 1'b1;
    lsu_if.m2s.arvalid = 1'b1;
    lsu_if.m2s.araddr  = 32'h3000_0400;
    for (int unsigned b = 0; b < 4; b++) begin
      core_if.s2m.rvalid = 1'b1;
      core_if.s2m.rdata  = 32'hB000_0000 + 32'(b);
      core_if.s2m.rlast  = (b == 3);
      settle();
      chk("t3_ifu_beat_rdata", ifu_if.s2m.rdata, 32'hB000_0000 + 32'(b));
      chk("t3_ifu_beat_rlast", 32'(ifu_if.s2m.rlast), (b == 3) ? 32'd1 : 32'd0);
      chk("t3_lsu_arready_held", 32'(lsu_if.s2m.arready), 32'd0);
      nxt();
    end
    core_if.s2m = '0;
    ifu_if.m2s  = '0;
    settle();
    chk("t3_lsu_arready_release", 32'(lsu_if.s2m.arready), 32'd1);
    nxt();
    lsu_if.m2s = '0;

    // Target stalls AR for five cycles; AR must hold steady
    for (int unsigned c = 0; c < 5; c++) begin
      settle();
      chk("t4_core_arvalid_stall", 32'(core_if.m2s.arvalid), 32'd1);
      chk("t4_core_araddr_stall", core_if.m2s.araddr, 32'h3000_0400);
      nxt();
    end
    core_if.s2m.arready = 1'b1;
    settle();
    chk("t4_core_arvalid_hs", 32'(core_if.m2s.arvalid), 32'd1);
    chk("t4_core_araddr_hs", core_if.m2s.araddr, 32'h3000_0400);
    nxt();
    core_if.s2m = '0;

    // Requester back-pressure for three cycles in DATA
    core_if.s2m.rvalid = 1'b1;
    core_if.s2m.rdata  = 32'hCAFE_F00D;
    core_if.s2m.rlast  = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      settle();
      chk("t5_core_rready_low", 32'(core_if.m2s.rready), 32'd0);
      chk("t5_lsu_rvalid_wait", 32'(lsu_if.s2m.rvalid), 32'd1);
      nxt();
    end
    lsu_if.m2s.rready = 1'b1;
    settle();
    chk("t5_core_rready_high", 32'(core_if.m2s.rready), 32'd1);
    chk("t5_lsu_rdata", lsu_if.s2m.rdata, 32'hCAFE_F00D);
    nxt();
    clear_inputs();

    // Reset in the middle of DATA abandons the transfer
    ifu_if.m2s.arvalid = 1'b1;
    ifu_if.m2s.araddr  = 32'h3000_0000;
    nxt();
    ifu_if.m2s = '0;
    core_if.s2m.arready = 1'b1;
    nxt();
    core_if.s2m = '0;
    core_if.s2m.rvalid = 1'b1;
    core_if.s2m.rdata  = 32'h5555_AAAA;
    ifu_if.m2s.rready  = 1'b1;
    settle();
    chk("t6_ifu_rvalid_pre", 32'(ifu_if.s2m.rvalid), 32'd1);
    reset = 1'b0;
    settle();
    chk("t6_ifu_rvalid_rst", 32'(ifu_if.s2m.rvalid), 32'd0);
    chk("t6_core_rready_rst", 32'(core_if.m2s.rready), 32'd0);
    nxt();
    reset = 1'b1;
    core_if.s2m.rlast = 1'b1;
    settle();
    chk("t6_ifu_rvalid_stray", 32'(ifu_if.s2m.rvalid), 32'd0);
    chk("t6_ifu_rdata_stray", ifu_if.s2m.rdata, 32'd0);
    chk("t6_lsu_rvalid_stray", 32'(lsu_if.s2m.rvalid), 32'd0);
    chk("t6_core_rready_stray", 32'(core_if.m2s.rready), 32'd0);
    chk("t6_core_arvalid_stray", 32'(core_if.m2s.arvalid), 32'd0);
    nxt();
    settle();
    chk("t6_ifu_rvalid_stray2", 32'(ifu_if.s2m.rvalid), 32'd0);
    chk("t6_core_rready_stray2", 32'(core_if.m2s.rready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
